// File: rtl/bft_pkg.sv
// Shared packet layout constants and routing helpers for the butterfly-fat-tree switches.
package bft_pkg;

    localparam int BFT_PKT_W  = 49;
    localparam int BFT_ADDR_W = 8;

    function automatic int valid_pos(input int pkt_w);
        return pkt_w - 1;
    endfunction

    function automatic int dest_msb(input int pkt_w);
        return pkt_w - 2;
    endfunction

    // The upper destination bits select the switch; the low leaf_w bits select the leaf.
    function automatic logic is_local(input logic [31:0] dest, input int leaf_w, input int sw_id);
        return (dest >> leaf_w) == 32'(sw_id);
    endfunction

endpackage

// File: rtl/bft_rr_arbiter.sv
// Round-robin arbiter granting up to max_grants requesters, scanning from the pointer.
// The pointer advances to the last winner + 1 only when something is granted.
module bft_rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1,
    localparam int CW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [N-1:0]  req,
    input  logic [CW-1:0] max_grants,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] win
);

    logic [IW-1:0] ptr_q;

    always_comb begin
        int idx;
        int cnt;
        idx = 0;
        cnt = 0;
        gnt = '0;
        win = ptr_q;
        for (int r = 0; r < N; r++) begin
            idx = int'(ptr_q) + r;
            if (idx >= N) idx = idx - N;
            if (req[idx] && cnt < int'(max_grants)) begin
                gnt[idx] = 1'b1;
                win      = IW'(idx);
                cnt      = cnt + 1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= '0;
        end else if (|gnt) begin
            ptr_q <= (int'(win) == N - 1) ? '0 : win + IW'(1);
        end
    end

endmodule

// File: rtl/bft_leaf_switch_p.sv
// Butterfly-fat-tree leaf switch: local leaf routing, uplink allocation with per-slot replay.
// Define BFT_STATS_EN to add the saturating resend_cnt statistics counter.
module bft_leaf_switch_p
    import bft_pkg::*;
#(
    parameter int N_LEAVES = 8,
    parameter int UP_PORTS = 4,
    parameter int PKT_W    = BFT_PKT_W,
    parameter int ADDR_W   = BFT_ADDR_W,
    parameter int SW_ID    = 0
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [UP_PORTS*PKT_W-1:0] din,
    input  logic [N_LEAVES*PKT_W-1:0] leaf_in,
    input  logic [UP_PORTS-1:0]       resend_up_in,
    output logic [UP_PORTS*PKT_W-1:0] bus_o,
    output logic [N_LEAVES*PKT_W-1:0] leaf_out,
    output logic [N_LEAVES-1:0]       resend,
    output logic [UP_PORTS-1:0]       resend_up_out
`ifdef BFT_STATS_EN
    ,
    output logic [31:0]               resend_cnt
`endif
);

    localparam int LEAF_W = $clog2(N_LEAVES);
    localparam int VB     = valid_pos(PKT_W);
    localparam int DM     = dest_msb(PKT_W);
    localparam int DL     = DM - ADDR_W + 1;
    localparam int LCW    = $clog2(N_LEAVES + 1);
    localparam int UCW    = $clog2(UP_PORTS + 1);
    localparam int UIW    = (UP_PORTS > 1) ? $clog2(UP_PORTS) : 1;

    typedef logic [PKT_W-1:0] pkt_t;

    pkt_t [N_LEAVES-1:0] leaf_pkt, leaf_d, leaf_q;
    pkt_t [UP_PORTS-1:0] din_pkt, bus_d, bus_q;
    logic [N_LEAVES-1:0] l_vld, l_loc, up_req, up_gnt, rs_d, rs_q;
    logic [UP_PORTS-1:0] d_vld, d_loc, busy, rsu_d, rsu_q;
    logic [LEAF_W-1:0]   l_port [N_LEAVES];
    logic [LEAF_W-1:0]   d_port [UP_PORTS];
    logic [LEAF_W-1:0]   up_win;
    logic [LCW-1:0]      up_max;

    logic [N_LEAVES-1:0][UP_PORTS-1:0] dn_up_req, dn_up_gnt;
    logic [N_LEAVES-1:0][N_LEAVES-1:0] dn_lf_req, dn_lf_gnt;
    logic [UIW-1:0]                    dn_up_win [N_LEAVES];
    logic [LEAF_W-1:0]                 dn_lf_win [N_LEAVES];

    assign leaf_pkt = leaf_in;
    assign din_pkt  = din;

    always_comb begin
        for (int i = 0; i < N_LEAVES; i++) begin
            l_vld[i]  = leaf_pkt[i][VB];
            l_loc[i]  = is_local(32'(leaf_pkt[i][DM -: ADDR_W]), LEAF_W, SW_ID);
            l_port[i] = leaf_pkt[i][DL +: LEAF_W];
        end
        for (int k = 0; k < UP_PORTS; k++) begin
            d_vld[k]  = din_pkt[k][VB];
            d_loc[k]  = is_local(32'(din_pkt[k][DM -: ADDR_W]), LEAF_W, SW_ID);
            d_port[k] = din_pkt[k][DL +: LEAF_W];
        end
    end

    always_comb begin
        dn_up_req = '0;
        dn_lf_req = '0;
        up_req    = '0;
        for (int k = 0; k < UP_PORTS; k++)
            if (d_vld[k] && d_loc[k]) dn_up_req[d_port[k]][k] = 1'b1;
        for (int i = 0; i < N_LEAVES; i++)
            if (l_vld[i]) begin
                if (l_loc[i]) dn_lf_req[l_port[i]][i] = 1'b1;
                else          up_req[i] = 1'b1;
            end
    end

    // Uplink contenders pre-empt leaves by zeroing the leaf arbiter's grant budget.
    for (genvar j = 0; j < N_LEAVES; j++) begin : g_down
        bft_rr_arbiter #(.N(UP_PORTS)) u_dn_up (
            .clk        (clk),
            .reset_n    (reset_n),
            .req        (dn_up_req[j]),
            .max_grants (UCW'(1)),
            .gnt        (dn_up_gnt[j]),
            .win        (dn_up_win[j])
        );
        bft_rr_arbiter #(.N(N_LEAVES)) u_dn_lf (
            .clk        (clk),
            .reset_n    (reset_n),
            .req        (dn_lf_req[j]),
            .max_grants ((|dn_up_req[j]) ? LCW'(0) : LCW'(1)),
            .gnt        (dn_lf_gnt[j]),
            .win        (dn_lf_win[j])
        );
    end

    always_comb begin
        int n_free;
        busy = resend_up_in & ~'0;
        for (int k = 0; k < UP_PORTS; k++) busy[k] = resend_up_in[k] & bus_q[k][VB];
        n_free = UP_PORTS - $countones(busy);
        up_max = LCW'((n_free > N_LEAVES) ? N_LEAVES : n_free);
    end

    bft_rr_arbiter #(.N(N_LEAVES)) u_up (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (up_req),
        .max_grants (up_max),
        .gnt        (up_gnt),
        .win        (up_win)
    );

    // Grants all lie in the window ending at up_win, so scanning from up_win+1 recovers RR order.
    always_comb begin
        int nf;
        int n;
        int idx;
        int fslot [UP_PORTS];
        nf    = 0;
        n     = 0;
        idx   = 0;
        bus_d = '0;
        for (int k = 0; k < UP_PORTS; k++) fslot[k] = 0;
        for (int k = 0; k < UP_PORTS; k++) begin
            if (busy[k]) begin
                bus_d[k] = bus_q[k];
            end else begin
                fslot[nf] = k;
                nf = nf + 1;
            end
        end
        for (int r = 0; r < N_LEAVES; r++) begin
            idx = (int'(up_win) + 1 + r) % N_LEAVES;
            if (up_gnt[idx] && n < nf) begin
                bus_d[fslot[n]] = leaf_pkt[idx];
                n = n + 1;
            end
        end
    end

    always_comb begin
        leaf_d = '0;
        rs_d   = '0;
        rsu_d  = '0;
        for (int j = 0; j < N_LEAVES; j++) begin
            if (|dn_up_gnt[j])      leaf_d[j] = din_pkt[dn_up_win[j]];
            else if (|dn_lf_gnt[j]) leaf_d[j] = leaf_pkt[dn_lf_win[j]];
        end
        for (int i = 0; i < N_LEAVES; i++)
            rs_d[i] = l_vld[i] & (l_loc[i] ? ~dn_lf_gnt[l_port[i]][i] : ~up_gnt[i]);
        for (int k = 0; k < UP_PORTS; k++)
            rsu_d[k] = d_vld[k] & d_loc[k] & ~dn_up_gnt[d_port[k]][k];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            leaf_q <= '0;
            bus_q  <= '0;
            rs_q   <= '0;
            rsu_q  <= '0;
        end else begin
            leaf_q <= leaf_d;
            bus_q  <= bus_d;
            rs_q   <= rs_d;
            rsu_q  <= rsu_d;
        end
    end

    assign leaf_out      = leaf_q;
    assign bus_o         = bus_q;
    assign resend        = rs_q;
    assign resend_up_out = rsu_q;

`ifdef BFT_STATS_EN
    logic [32:0] cnt_sum;

    always_comb
        cnt_sum = {1'b0, resend_cnt} + 33'($countones(rs_q)) + 33'($countones(rsu_q));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)        resend_cnt <= '0;
        else if (cnt_sum[32]) resend_cnt <= '1;
        else                 resend_cnt <= cnt_sum[31:0];
    end
`endif

endmodule

// File: tb/tb_bft_leaf_switch_p.sv
// Randomized bench for bft_leaf_switch_p against a queue-based reference model.
module tb_bft_leaf_switch_p;

    localparam int N  = 8;
    localparam int U  = 4;
    localparam int PW = 49;
    localparam int AW = 8;
    localparam int SW = 0;

    typedef logic [PW-1:0] pkt_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    pkt_t [U-1:0] din_v;
    pkt_t [N-1:0] leaf_v;
    logic [U-1:0] rui;
    logic [U*PW-1:0] bus_o;
    logic [N*PW-1:0] leaf_out;
    logic [N-1:0] resend;
    logic [U-1:0] rsu;
`ifdef BFT_STATS_EN
    logic [31:0] resend_cnt;
`endif

    always #5 clk = ~clk;

    bft_leaf_switch_p #(.N_LEAVES(N), .UP_PORTS(U), .PKT_W(PW), .ADDR_W(AW), .SW_ID(SW)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .din           (din_v),
        .leaf_in       (leaf_v),
        .resend_up_in  (rui),
        .bus_o         (bus_o),
        .leaf_out      (leaf_out),
        .resend        (resend),
        .resend_up_out (rsu)
`ifdef BFT_STATS_EN
        ,
        .resend_cnt    (resend_cnt)
`endif
    );

    int checks = 0;
    int failures = 0;

    int dn_up_p [N];
    int dn_lf_p [N];
    int up_p;
    pkt_t [N-1:0] e_leaf;
    pkt_t [U-1:0] e_bus;
    logic [N-1:0] e_rs;
    logic [U-1:0] e_rsu;
    longint e_cnt;

    function automatic bit m_vld(input pkt_t p);
        return p[PW-1];
    endfunction

    function automatic int m_dest(input pkt_t p);
        return int'(p[PW-2 -: AW]);
    endfunction

    function automatic bit m_loc(input pkt_t p);
        return (m_dest(p) / N) == SW;
    endfunction

    function automatic pkt_t mk(input int dest, input logic [39:0] payload);
        pkt_t p;
        p = {1'b1, 8'(dest), payload};
        return p;
    endfunction

    function automatic int pick(input logic [31:0] m, input int p, input int n);
        for (int r = 0; r < n; r++)
            if (m[(p + r) % n]) return (p + r) % n;
        return -1;
    endfunction

    task automatic model_reset();
        for (int j = 0; j < N; j++) begin
            dn_up_p[j] = 0;
            dn_lf_p[j] = 0;
        end
        up_p = 0;
        e_leaf = '0;
        e_bus = '0;
        e_rs = '0;
        e_rsu = '0;
        e_cnt = 0;
    endtask

    task automatic model_step();
        pkt_t [N-1:0] nl;
        pkt_t [U-1:0] nb;
        logic [N-1:0] nrs;
        logic [U-1:0] nrsu;
        logic [31:0] upm, lfm;
        int freeq[$];
        int w, last;
        bit granted;
        e_cnt = e_cnt + $countones(e_rs) + $countones(e_rsu);
        if (e_cnt > 64'hFFFF_FFFF) e_cnt = 64'hFFFF_FFFF;
        nl = '0; nb = '0; nrs = '0; nrsu = '0;
        for (int j = 0; j < N; j++) begin
            upm = 0; lfm = 0;
            for (int k = 0; k < U; k++)
                if (m_vld(din_v[k]) && m_loc(din_v[k]) && m_dest(din_v[k]) % N == j) upm[k] = 1'b1;
            for (int i = 0; i < N; i++)
                if (m_vld(leaf_v[i]) && m_loc(leaf_v[i]) && m_dest(leaf_v[i]) % N == j) lfm[i] = 1'b1;
            if (upm != 0) begin
                w = pick(upm, dn_up_p[j], U);
                nl[j] = din_v[w];
                dn_up_p[j] = (w + 1) % U;
                for (int k = 0; k < U; k++) if (upm[k] && k != w) nrsu[k] = 1'b1;
                for (int i = 0; i < N; i++) if (lfm[i]) nrs[i] = 1'b1;
            end else if (lfm != 0) begin
                w = pick(lfm, dn_lf_p[j], N);
                nl[j] = leaf_v[w];
                dn_lf_p[j] = (w + 1) % N;
                for (int i = 0; i < N; i++) if (lfm[i] && i != w) nrs[i] = 1'b1;
            end
        end
        for (int k = 0; k < U; k++) begin
            if (rui[k] && m_vld(e_bus[k])) nb[k] = e_bus[k];
            else freeq.push_back(k);
        end
        granted = 0; last = 0;
        for (int r = 0; r < N; r++) begin
            int i;
            i = (up_p + r) % N;
            if (m_vld(leaf_v[i]) && !m_loc(leaf_v[i])) begin
                if (freeq.size() > 0) begin
                    nb[freeq.pop_front()] = leaf_v[i];
                    last = i;
                    granted = 1;
                end else begin
                    nrs[i] = 1'b1;
                end
            end
        end
        if (granted) up_p = (last + 1) % N;
        e_leaf = nl; e_bus = nb; e_rs = nrs; e_rsu = nrsu;
    endtask

    task automatic chk(input string nm, input logic [399:0] act, input logic [399:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic check_outputs();
        chk("leaf_out", leaf_out, e_leaf);
        chk("bus_o", bus_o, e_bus);
        chk("resend", resend, e_rs);
        chk("resend_up_out", rsu, e_rsu);
`ifdef BFT_STATS_EN
        chk("resend_cnt", resend_cnt, e_cnt[31:0]);
`endif
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        din_v = '0;
        leaf_v = '0;
        rui = '0;
    endtask

    initial begin
        pkt_t p5;
        clear_inputs();
        model_reset();
        #12;
        check_outputs();
        @(negedge clk);
        reset_n = 1'b1;

        // local route
        leaf_v[2] = mk(8'h05, 40'h11);
        cycle();
        chk("t2_leaf5", leaf_out[5*PW +: PW], mk(8'h05, 40'h11));
        chk("t2_resend", resend, 8'h00);

        // conflict on leaf 6: din first, then leaves in RR order
        clear_inputs();
        leaf_v[1] = mk(8'h06, 40'h21);
        leaf_v[3] = mk(8'h06, 40'h23);
        din_v[0]  = mk(8'h06, 40'h30);
        cycle();
        chk("t3_din_wins", leaf_out[6*PW +: PW], mk(8'h06, 40'h30));
        chk("t3_resend", resend, 8'b0000_1010);
        din_v[0] = '0;
        cycle();
        chk("t3_leaf1_wins", leaf_out[6*PW +: PW], mk(8'h06, 40'h21));
        chk("t3_resend_b", resend, 8'b0000_1000);
`ifdef BFT_STATS_EN
        chk("t6_cnt_plus2", resend_cnt, 32'd2);
`endif
        cycle();
        chk("t3_leaf3_wins", leaf_out[6*PW +: PW], mk(8'h06, 40'h23));
        chk("t3_resend_c", resend, 8'b0000_0010);

        // uplink overflow
        clear_inputs();
        for (int i = 0; i < 6; i++) leaf_v[i] = mk(8'h40, 40'(32'h400 + i));
        cycle();
        chk("t4_slot0", bus_o[0*PW +: PW], mk(8'h40, 40'h400));
        chk("t4_slot3", bus_o[3*PW +: PW], mk(8'h40, 40'h403));
        chk("t4_resend", resend, 8'b0011_0000);
        cycle();
        chk("t4_slot0_b", bus_o[0*PW +: PW], mk(8'h40, 40'h404));
        chk("t4_slot2_b", bus_o[2*PW +: PW], mk(8'h40, 40'h400));
        chk("t4_resend_b", resend, 8'b0000_1100);

        // replay of slot 2
        clear_inputs();
        p5 = 49'h1_2345_6789_ABCD;
        leaf_v[2] = mk(8'h80, 40'h52);
        leaf_v[3] = mk(8'h80, 40'h53);
        leaf_v[4] = p5;
        cycle();
        chk("t5_slot2", bus_o[2*PW +: PW], p5);
        clear_inputs();
        rui = 4'b0100;
        leaf_v[6] = mk(8'h80, 40'h66);
        cycle();
        chk("t5_replay", bus_o[2*PW +: PW], p5);
        chk("t5_new_slot0", bus_o[0*PW +: PW], mk(8'h80, 40'h66));
        leaf_v = '0;
        cycle();
        chk("t5_replay_again", bus_o[2*PW +: PW], p5);

        // randomized traffic
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(99) < 60) begin
                    int d;
                    d = ($urandom_range(1) == 0) ? int'($urandom_range(N - 1)) : int'($urandom_range(255, N));
                    leaf_v[i] = mk(d, 40'({$urandom, $urandom}));
                end else begin
                    leaf_v[i] = pkt_t'(48'({$urandom, $urandom}));
                end
            end
            for (int k = 0; k < U; k++) begin
                if ($urandom_range(99) < 40) begin
                    int d;
                    d = ($urandom_range(99) < 80) ? int'($urandom_range(N - 1)) : int'($urandom_range(255, N));
                    din_v[k] = mk(d, 40'({$urandom, $urandom}));
                end else begin
                    din_v[k] = '0;
                end
            end
            rui = 4'($urandom);
            cycle();
        end

        // reset in the middle of traffic
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        chk("t1_leaf_out_zero", leaf_out, '0);
        @(negedge clk);
        reset_n = 1'b1;
        clear_inputs();
        leaf_v[0] = mk(8'h03, 40'hAB);
        cycle();
        chk("t1_fresh_fwd", leaf_out[3*PW +: PW], mk(8'h03, 40'hAB));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
